// File: rtl/vga_scan_ctrl.sv
// VGA frame scan controller: timing, tile-map walk, sprite overlay and map-port arbitration.
// Optional: define SCAN_BORDER_EN to force a WALL frame around the visible area.
module vga_scan_ctrl #(
    parameter int PIX_DIV    = 4,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CELL_SHIFT = 4,
    parameter int MAP_AW     = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        tank_x,
    input  logic [9:0]        tank_y,
    input  logic [9:0]        bullet_x,
    input  logic [9:0]        bullet_y,
    input  logic              bullet_vld,
    input  logic              game_req,
    input  logic [MAP_AW-1:0] game_addr,
    input  logic              game_we,
    input  logic [3:0]        game_wdata,
    output logic              game_gnt,
    output logic [MAP_AW-1:0] map_addr,
    output logic              map_we,
    output logic [3:0]        map_wdata,
    input  logic [3:0]        map_rdata,
    output logic [3:0]        category,
    output logic              hsync,
    output logic              vsync,
    output logic              active,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = $clog2(PIX_DIV);
    localparam int MAP_W   = H_ACTIVE >> CELL_SHIFT;

    localparam logic [3:0] CAT_NONE   = 4'd0;
    localparam logic [3:0] CAT_WALL   = 4'd1;
    localparam logic [3:0] CAT_TANK   = 4'd2;
    localparam logic [3:0] CAT_BULLET = 4'd3;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    logic [DW-1:0] div_cnt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          tick;
    logic          h_last;
    logic          v_last;

    assign tick   = (div_cnt == DW'(PIX_DIV - 1));
    assign h_last = (h_cnt == HW'(H_TOTAL - 1));
    assign v_last = (v_cnt == VW'(V_TOTAL - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
            if (tick) begin
                if (h_last) begin
                    h_cnt <= '0;
                    v_cnt <= v_last ? '0 : v_cnt + VW'(1);
                end else begin
                    h_cnt <= h_cnt + HW'(1);
                end
            end
        end
    end

    // Pixel decode for S0; sprite bounds are compared at 11 bits so X+W-1 cannot wrap.
    logic [10:0] px;
    logic [10:0] py;
    logic        in_tank;
    logic        in_bullet;
    logic        is_border;
    logic        pix_active;
    logic        pix_hs_n;
    logic        pix_vs_n;
    logic [3:0]  pix_cat;

    assign px = 11'(h_cnt);
    assign py = 11'(v_cnt);

    assign in_tank   = (px >= {1'b0, tank_x})   && (px <= {1'b0, tank_x} + 11'd15) &&
                       (py >= {1'b0, tank_y})   && (py <= {1'b0, tank_y} + 11'd15);
    assign in_bullet = (px >= {1'b0, bullet_x}) && (px <= {1'b0, bullet_x} + 11'd3) &&
                       (py >= {1'b0, bullet_y}) && (py <= {1'b0, bullet_y} + 11'd3);

    assign pix_active = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    assign pix_hs_n   = !((h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                          (h_cnt <= HW'(H_ACTIVE + H_FP + H_SYNC - 1)));
    assign pix_vs_n   = !((v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                          (v_cnt <= VW'(V_ACTIVE + V_FP + V_SYNC - 1)));

`ifdef SCAN_BORDER_EN
    assign is_border = (h_cnt == '0) || (h_cnt == HW'(H_ACTIVE - 1)) ||
                       (v_cnt == '0) || (v_cnt == VW'(V_ACTIVE - 1));
`else
    assign is_border = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pix_cat = map_rdata;
        if (!pix_active)                   pix_cat = CAT_NONE;
        else if (bullet_vld && in_bullet)  pix_cat = CAT_BULLET;
        else if (in_tank)                  pix_cat = CAT_TANK;
        else if (is_border)                pix_cat = CAT_WALL;
    end

    // S1: one-tick output stage; syncs ride the same register as the category.
    always_ff @(posedge clk) begin
        if (rst) begin
            category    <= CAT_NONE;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            active      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= tick && h_last && v_last;
            if (tick) begin
                category <= pix_cat;
                hsync    <= pix_hs_n;
                vsync    <= pix_vs_n;
                active   <= pix_active;
            end
        end
    end

    // Map-port arbiter: the grant window opens at the first blanking line and closes before line 0.
    arb_state_t state;
    arb_state_t state_nxt;
    logic [MAP_AW-1:0] scan_addr;

    assign scan_addr = MAP_AW'(32'(v_cnt >> CELL_SHIFT) * 32'(MAP_W) + 32'(h_cnt >> CELL_SHIFT));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:
                if (game_req && tick && (v_cnt == VW'(V_ACTIVE)) && (h_cnt == '0))
                    state_nxt = GRANT;
            GRANT:
                if (!game_req || (tick && h_last && v_last))
                    state_nxt = IDLE;
            default:
                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        game_gnt  = (state == GRANT);
        map_addr  = scan_addr;
        map_we    = 1'b0;
        map_wdata = 4'd0;
        if (state == GRANT) begin
            map_addr  = game_addr;
            map_we    = game_we;
            map_wdata = game_wdata;
        end
    end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl on a reduced 80x55 timing so several frames fit the run.
module tb_vga_scan_ctrl;

    localparam int PD  = 2;
    localparam int HA  = 64, HFP = 4, HS = 8, HBP = 4;
    localparam int VA  = 48, VFP = 2, VS = 2, VBP = 3;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int AW  = 11;

`ifdef SCAN_BORDER_EN
    localparam logic [3:0] BORDER_EXP = 4'd1;
`else
    localparam logic [3:0] BORDER_EXP = 4'd0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [9:0]    tank_x = 10'd1000, tank_y = 10'd1000;
    logic [9:0]    bullet_x = 10'd0, bullet_y = 10'd0;
    logic          bullet_vld = 1'b0;
    logic          game_req = 1'b0;
    logic [AW-1:0] game_addr = '0;
    logic          game_we = 1'b0;
    logic [3:0]    game_wdata = 4'd0;
    logic          game_gnt;
    logic [AW-1:0] map_addr;
    logic          map_we;
    logic [3:0]    map_wdata;
    logic [3:0]    map_rdata;
    logic [3:0]    category;
    logic          hsync, vsync, active, frame_start;

    vga_scan_ctrl #(
        .PIX_DIV(PD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .CELL_SHIFT(4), .MAP_AW(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .tank_x(tank_x), .tank_y(tank_y),
        .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_vld(bullet_vld),
        .game_req(game_req), .game_addr(game_addr), .game_we(game_we), .game_wdata(game_wdata),
        .game_gnt(game_gnt),
        .map_addr(map_addr), .map_we(map_we), .map_wdata(map_wdata), .map_rdata(map_rdata),
        .category(category), .hsync(hsync), .vsync(vsync), .active(active),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Map RAM model with synchronous read; bench fills and pokes go through this process only.
    logic [3:0]    ram [0:(1<<AW)-1];
    logic          fill_req = 1'b0, poke_req = 1'b0;
    logic [3:0]    fill_val = 4'd0, poke_val = 4'd0;
    logic [AW-1:0] poke_addr = '0;

    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= fill_val;
        end else if (poke_req) begin
            ram[poke_addr] <= poke_val;
        end else if (map_we) begin
            ram[map_addr] <= map_wdata;
        end
        map_rdata <= ram[map_addr];
    end

    // Reference raster position: pixel (m_h, m_v), m_div clocks into it.
    int m_div = 0, m_h = 0, m_v = 0;
    always @(posedge clk) begin
        if (rst) begin
            m_div <= 0; m_h <= 0; m_v <= 0;
        end else if (m_div == PD - 1) begin
            m_div <= 0;
            if (m_h == HT - 1) begin
                m_h <= 0;
                m_v <= (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h <= m_h + 1;
            end
        end else begin
            m_div <= m_div + 1;
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Stop at the first clock of pixel (h,v), sampled on the falling edge.
    task automatic goto(input int h, input int v);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_div == 0 && m_h == h && m_v == v) && n < 2 * HT * VT * PD);
        if (n >= 2 * HT * VT * PD) begin
            n_total++;
            $error("FAIL goto_timeout: observed no pixel (%0d,%0d) expected it within 2 frames", h, v);
        end
    endtask

    task automatic fill(input logic [3:0] val);
        fill_val = val; fill_req = 1'b1;
        @(negedge clk);
        fill_req = 1'b0;
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [3:0] val);
        poke_addr = a; poke_val = val; poke_req = 1'b1;
        @(negedge clk);
        poke_req = 1'b0;
    endtask

    int hlow, hfirst, vlines, vfirst, fs_cnt;

    initial begin
        // Reset state, with the map cleared and one WALL tile at address 5 (tile 1,1).
        repeat (2) @(negedge clk);
        fill(4'd0);
        poke(11'd5, 4'd1);
        check("rst_category", category, 4'd0);
        check("rst_hsync", hsync, 1'b1);
        check("rst_vsync", vsync, 1'b1);
        check("rst_active", active, 1'b0);
        check("rst_gnt", game_gnt, 1'b0);
        check("rst_map_we", map_we, 1'b0);
        check("rst_frame_start", frame_start, 1'b0);
        rst = 1'b0;

        // Frame timing over one full frame from reset.
        hlow = 0; hfirst = -1; vlines = 0; vfirst = -1; fs_cnt = 0;
        for (int t = 0; t < HT * VT; t++) begin
            repeat (PD) @(negedge clk);
            if (m_v == 5 && !hsync) begin
                hlow++;
                if (hfirst < 0) hfirst = m_h;
            end
            if (m_h == 1 && !vsync) begin
                vlines++;
                if (vfirst < 0) vfirst = m_v;
            end
            if (frame_start) fs_cnt++;
        end
        check("hsync_low_ticks", hlow, HS);
        check("hsync_first_low", hfirst, HA + HFP + 1);
        check("vsync_low_lines", vlines, VS);
        check("vsync_first_line", vfirst, VA + VFP);
        check("frame_start_count", fs_cnt, 1);
        check("frame_start_at_wrap", frame_start, 1'b1);

        // Tile walk and border behaviour; category shows the previous pixel.
        goto(11, 0);  check("border_top", category, BORDER_EXP);
        goto(1, 5);   check("border_left", category, BORDER_EXP);
        goto(11, 5);  check("interior_zero", category, 4'd0);
        goto(64, 5);  check("border_right", category, BORDER_EXP);
        goto(32, 15); check("tile_above", category, 4'd0);
        goto(16, 16); check("tile_left", category, 4'd0);
                      check("map_addr_16_16", map_addr, 11'd5);
        goto(17, 16); check("tile_first_px", category, 4'd1);
        goto(33, 16); check("tile_right", category, 4'd0);
        goto(32, 31); check("tile_last_px", category, 4'd1);
        goto(17, 32); check("tile_below", category, 4'd0);
        goto(11, 47); check("border_bottom", category, BORDER_EXP);

        // Sprite priority over an all-WALL map.
        goto(0, 50);
        fill(4'd1);
        tank_x = 10'd20; tank_y = 10'd10;
        bullet_x = 10'd24; bullet_y = 10'd12; bullet_vld = 1'b1;
        goto(21, 10); check("tank_corner", category, 4'd2);
        goto(36, 10); check("tank_right_edge", category, 4'd2);
        goto(37, 10); check("past_tank", category, 4'd1);
        goto(25, 12); check("bullet_corner", category, 4'd3);
        goto(29, 12); check("past_bullet", category, 4'd2);
        goto(28, 15); check("bullet_last_px", category, 4'd3);
        goto(0, 40);
        bullet_vld = 1'b0;
        goto(0, 10);
        game_req = 1'b1;
        goto(25, 12); check("bullet_invalid", category, 4'd2);

        // Arbitration: request raised mid-frame waits for the first blanking line.
        game_addr = 11'd5; game_wdata = 4'd9; game_we = 1'b1;
        goto(0, VA);  check("gnt_before_window", game_gnt, 1'b0);
                      check("idle_map_we", map_we, 1'b0);
                      check("idle_scan_addr", map_addr, 11'd12);
        goto(1, VA);  check("gnt_rise", game_gnt, 1'b1);
                      check("gnt_map_we", map_we, 1'b1);
                      check("gnt_map_addr", map_addr, 11'd5);
                      check("gnt_map_wdata", map_wdata, 4'd9);
        @(negedge clk);
        game_we = 1'b0;
        goto(HT - 1, VT - 1); check("gnt_last_pixel", game_gnt, 1'b1);
        goto(0, 0);           check("gnt_forced_revoke", game_gnt, 1'b0);
        goto(1, VA);          check("gnt_next_frame", game_gnt, 1'b1);
        game_req = 1'b0;
        @(negedge clk);       check("gnt_req_drop", game_gnt, 1'b0);
        goto(0, VA + 2);
        game_req = 1'b1;
        goto(HT - 1, VT - 1); check("gnt_midvblank_req", game_gnt, 1'b0);
        goto(0, 0);
        game_req = 1'b0;

        // Written code 9 passes through; then a mid-frame reset.
        tank_x = 10'd1000; tank_y = 10'd1000;
        goto(17, 16); check("code_passthrough", category, 4'd9);
        goto(50, 20); check("pre_reset_category", category, 4'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_category", category, 4'd0);
        check("midrst_hsync", hsync, 1'b1);
        check("midrst_active", active, 1'b0);
        check("midrst_frame_start", frame_start, 1'b0);
        rst = 1'b0;
        goto(1, 0);   check("restart_category", category, 4'd1);
                      check("restart_active", active, 1'b1);
        goto(HA + HFP + 1, 0); check("restart_hsync", hsync, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
